// File: rtl/csr_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_regfile_pkg
//  Description : Shared constants for the CSR register file: bus widths,
//                CSR numbers, field bit positions, write masks, reset values
//                and exception codes, plus the masked-write merge helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_regfile_pkg;

  // Bus widths
  localparam int c_DATA_W     = 32;
  localparam int c_CSR_NUM_W  = 14;
  localparam int c_HWI_W      = 8;
  localparam int c_ECODE_W    = 6;
  localparam int c_ESUBCODE_W = 9;
  localparam int c_NUM_SAVE   = 4;

  // CSR numbers
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_CRMD   = 14'h000;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_PRMD   = 14'h001;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_ECFG   = 14'h004;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_ESTAT  = 14'h005;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_ERA    = 14'h006;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_EENTRY = 14'h00C;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_SAVE0  = 14'h030;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_SAVE1  = 14'h031;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_SAVE2  = 14'h032;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_SAVE3  = 14'h033;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_TID    = 14'h040;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_TCFG   = 14'h041;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_TVAL   = 14'h042;
  localparam logic [c_CSR_NUM_W-1:0] c_CSR_TICLR  = 14'h044;

  // CRMD fields
  localparam int c_CRMD_PLV_LO = 0;
  localparam int c_CRMD_PLV_HI = 1;
  localparam int c_CRMD_IE     = 2;

  // PRMD fields
  localparam int c_PRMD_PPLV_LO = 0;
  localparam int c_PRMD_PPLV_HI = 1;
  localparam int c_PRMD_PIE     = 2;

  // ESTAT fields
  localparam int c_ESTAT_IS_SW_LO = 0;
  localparam int c_ESTAT_IS_SW_HI = 1;
  localparam int c_ESTAT_IS_HW_LO = 2;
  localparam int c_ESTAT_IS_HW_HI = 9;
  localparam int c_ESTAT_IS_TI    = 11;
  localparam int c_ESTAT_IS_IPI   = 12;
  localparam int c_ESTAT_IS_HI    = 12;
  localparam int c_ESTAT_ECODE_LO = 16;
  localparam int c_ESTAT_ECODE_HI = 21;
  localparam int c_ESTAT_ESUB_LO  = 22;
  localparam int c_ESTAT_ESUB_HI  = 30;

  // TCFG / TICLR fields
  localparam int c_TCFG_EN         = 0;
  localparam int c_TCFG_PERIODIC   = 1;
  localparam int c_TCFG_INITVAL_LO = 2;
  localparam int c_TCFG_INITVAL_HI = 31;
  localparam int c_TICLR_CLR       = 0;

  // Writable-bit masks
  localparam logic [c_DATA_W-1:0] c_CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [c_DATA_W-1:0] c_PRMD_WMASK   = 32'h0000_0007;
  localparam logic [c_DATA_W-1:0] c_ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [c_DATA_W-1:0] c_EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [c_DATA_W-1:0] c_FULL_WMASK   = 32'hFFFF_FFFF;

  // Reset values
  localparam logic [c_DATA_W-1:0] c_CRMD_RESET = 32'h0000_0008;
  localparam logic [c_DATA_W-1:0] c_TVAL_RESET = 32'hFFFF_FFFF;

  // Exception codes
  localparam logic [c_ECODE_W-1:0] c_ECODE_INT = 6'h00;
  localparam logic [c_ECODE_W-1:0] c_ECODE_PIL = 6'h01;
  localparam logic [c_ECODE_W-1:0] c_ECODE_PIS = 6'h02;
  localparam logic [c_ECODE_W-1:0] c_ECODE_PIF = 6'h03;
  localparam logic [c_ECODE_W-1:0] c_ECODE_PME = 6'h04;
  localparam logic [c_ECODE_W-1:0] c_ECODE_PPI = 6'h07;
  localparam logic [c_ECODE_W-1:0] c_ECODE_ADE = 6'h08;
  localparam logic [c_ECODE_W-1:0] c_ECODE_ALE = 6'h09;
  localparam logic [c_ECODE_W-1:0] c_ECODE_SYS = 6'h0B;
  localparam logic [c_ECODE_W-1:0] c_ECODE_BRK = 6'h0C;
  localparam logic [c_ECODE_W-1:0] c_ECODE_INE = 6'h0D;
  localparam logic [c_ECODE_W-1:0] c_ECODE_IPE = 6'h0E;
  localparam logic [c_ECODE_W-1:0] c_ECODE_FPD = 6'h0F;
  localparam logic [c_ECODE_W-1:0] c_ECODE_FPE = 6'h12;

  // Masked write: bits selected by wmask take the new value, others keep
  // the old one; non-implemented bits are forced to zero.
  function automatic logic [c_DATA_W-1:0] csr_merge(
    input logic [c_DATA_W-1:0] old_val,
    input logic [c_DATA_W-1:0] wvalue,
    input logic [c_DATA_W-1:0] wmask,
    input logic [c_DATA_W-1:0] writable
  );
    return ((wvalue & wmask) | (old_val & ~wmask)) & writable;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_regfile_if
//  Description : Bundle of the CSR read/write port, writeback commit events,
//                interrupt lines and the exception-entry outputs.
//  Modports    : master - pipeline side (drives requests, sees results)
//                slave  - CSR register file side
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_regfile_if;
  import csr_regfile_pkg::*;

  logic                    csr_re;
  logic [c_CSR_NUM_W-1:0]  csr_num;
  logic [c_DATA_W-1:0]     csr_rvalue;
  logic                    csr_we;
  logic [c_DATA_W-1:0]     csr_wmask;
  logic [c_DATA_W-1:0]     csr_wvalue;
  logic                    wb_ex;
  logic [c_ECODE_W-1:0]    wb_ecode;
  logic [c_ESUBCODE_W-1:0] wb_esubcode;
  logic                    eret_flush;
  logic [c_DATA_W-1:0]     wb_pc;
  logic [c_HWI_W-1:0]      hw_int_in;
  logic                    ipi_int_in;
  logic [c_DATA_W-1:0]     ex_entry;
  logic [c_DATA_W-1:0]     ertn_pc;
  logic                    has_int;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, eret_flush, wb_pc,
           hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_pc, has_int
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, eret_flush, wb_pc,
           hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_pc, has_int
  );
endinterface
`default_nettype wire

// File: rtl/csr_timer.sv
`default_nettype none
// ============================================================================
//  Module      : csr_timer
//  Description : Constant-frequency timer: TCFG register, TVAL down-counter
//                and the timer-interrupt pending bit (ESTAT.IS[11]).
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                i_tcfg_we    - masked write to TCFG this cycle
//                i_wmask/i_wvalue - write mask / data
//                i_ticlr      - TICLR.CLR written with 1 this cycle
//                o_tcfg, o_tval - register values for readback
//                o_ti         - timer interrupt pending
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_timer
  import csr_regfile_pkg::*;
(
  input  wire                 clk,
  input  wire                 reset,
  input  wire                 i_tcfg_we,
  input  wire  [c_DATA_W-1:0] i_wmask,
  input  wire  [c_DATA_W-1:0] i_wvalue,
  input  wire                 i_ticlr,
  output logic [c_DATA_W-1:0] o_tcfg,
  output logic [c_DATA_W-1:0] o_tval,
  output logic                o_ti
);

  logic [c_DATA_W-1:0] r_tcfg;
  logic [c_DATA_W-1:0] r_tval;
  logic                r_ti;
  logic [c_DATA_W-1:0] w_tcfg_next;
  logic [c_DATA_W-1:0] w_reload_new;
  logic [c_DATA_W-1:0] w_reload_cur;
  logic                w_tval_zero;
  logic                w_fire;

  assign w_tcfg_next  = csr_merge(r_tcfg, i_wvalue, i_wmask, c_FULL_WMASK);
  assign w_reload_new = {w_tcfg_next[c_TCFG_INITVAL_HI:c_TCFG_INITVAL_LO], 2'b00};
  assign w_reload_cur = {r_tcfg[c_TCFG_INITVAL_HI:c_TCFG_INITVAL_LO], 2'b00};
  assign w_tval_zero  = (r_tval == '0);
  assign w_fire       = r_tcfg[c_TCFG_EN] && w_tval_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcfg <= '0;
      r_tval <= c_TVAL_RESET;
      r_ti   <= 1'b0;
    end else begin
      if (i_tcfg_we) begin
        r_tcfg <= w_tcfg_next;
      end
      // A write that enables the timer restarts the count from InitVal.
      // All-ones is the parked state of an expired one-shot timer.
      if (i_tcfg_we && w_tcfg_next[c_TCFG_EN]) begin
        r_tval <= w_reload_new;
      end else if (r_tcfg[c_TCFG_EN] && (r_tval != c_TVAL_RESET)) begin
        if (w_tval_zero && r_tcfg[c_TCFG_PERIODIC]) begin
          r_tval <= w_reload_cur;
        end else begin
          r_tval <= r_tval - 32'd1;
        end
      end
      // Setting beats a simultaneous clear so no expiry is ever lost.
      if (w_fire) begin
        r_ti <= 1'b1;
      end else if (i_ticlr) begin
        r_ti <= 1'b0;
      end
    end
  end

  assign o_tcfg = r_tcfg;
  assign o_tval = r_tval;
  assign o_ti   = r_ti;

endmodule
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : csr_regfile
//  Description : Control/status register file: CRMD, PRMD, ECFG, ESTAT, ERA,
//                EENTRY, SAVE0-3, TID and the timer CSRs. Handles masked
//                writes, exception entry and ertn return state, interrupt
//                sampling and the pending-interrupt indication.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - csr_regfile_if.slave (read/write port, commit
//                             events, interrupt lines, ex_entry, ertn_pc,
//                             has_int)
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  wire           clk,
  input  wire           reset,
  csr_regfile_if.slave  bus
);

  logic [c_DATA_W-1:0]     r_crmd;
  logic [c_DATA_W-1:0]     r_prmd;
  logic [c_DATA_W-1:0]     r_ecfg;
  logic [1:0]              r_is_sw;
  logic [c_HWI_W-1:0]      r_is_hw;
  logic                    r_is_ipi;
  logic [c_ECODE_W-1:0]    r_ecode;
  logic [c_ESUBCODE_W-1:0] r_esubcode;
  logic [c_DATA_W-1:0]     r_era;
  logic [c_DATA_W-1:0]     r_eentry;
  logic [c_DATA_W-1:0]     r_save [c_NUM_SAVE];
  logic [c_DATA_W-1:0]     r_tid;

  logic [c_DATA_W-1:0]     w_estat;
  logic [c_DATA_W-1:0]     w_tcfg;
  logic [c_DATA_W-1:0]     w_tval;
  logic                    w_ti;
  logic [c_DATA_W-1:0]     w_rvalue;
  logic [c_DATA_W-1:0]     w_wv;
  logic [c_DATA_W-1:0]     w_wm;

  logic w_we_crmd, w_we_prmd, w_we_ecfg, w_we_estat;
  logic w_we_era, w_we_eentry, w_we_tid, w_we_tcfg, w_ticlr;

  assign w_wv = bus.csr_wvalue;
  assign w_wm = bus.csr_wmask;

  assign w_we_crmd   = bus.csr_we && (bus.csr_num == c_CSR_CRMD);
  assign w_we_prmd   = bus.csr_we && (bus.csr_num == c_CSR_PRMD);
  assign w_we_ecfg   = bus.csr_we && (bus.csr_num == c_CSR_ECFG);
  assign w_we_estat  = bus.csr_we && (bus.csr_num == c_CSR_ESTAT);
  assign w_we_era    = bus.csr_we && (bus.csr_num == c_CSR_ERA);
  assign w_we_eentry = bus.csr_we && (bus.csr_num == c_CSR_EENTRY);
  assign w_we_tid    = bus.csr_we && (bus.csr_num == c_CSR_TID);
  assign w_we_tcfg   = bus.csr_we && (bus.csr_num == c_CSR_TCFG);
  assign w_ticlr     = bus.csr_we && (bus.csr_num == c_CSR_TICLR) &&
                       w_wm[c_TICLR_CLR] && w_wv[c_TICLR_CLR];

  // Within each block the later assignment wins, which gives the per-field
  // priority exception > ertn > software write while untouched fields of
  // the same write still land.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd <= c_CRMD_RESET;
      r_prmd <= '0;
    end else begin
      if (w_we_crmd) begin
        r_crmd <= csr_merge(r_crmd, w_wv, w_wm, c_CRMD_WMASK);
      end
      if (w_we_prmd) begin
        r_prmd <= csr_merge(r_prmd, w_wv, w_wm, c_PRMD_WMASK);
      end
      if (bus.wb_ex) begin
        r_prmd[c_PRMD_PPLV_HI:c_PRMD_PPLV_LO] <= r_crmd[c_CRMD_PLV_HI:c_CRMD_PLV_LO];
        r_prmd[c_PRMD_PIE]                    <= r_crmd[c_CRMD_IE];
        r_crmd[c_CRMD_PLV_HI:c_CRMD_PLV_LO]   <= 2'b00;
        r_crmd[c_CRMD_IE]                     <= 1'b0;
      end else if (bus.eret_flush) begin
        r_crmd[c_CRMD_PLV_HI:c_CRMD_PLV_LO]   <= r_prmd[c_PRMD_PPLV_HI:c_PRMD_PPLV_LO];
        r_crmd[c_CRMD_IE]                     <= r_prmd[c_PRMD_PIE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ecfg     <= '0;
      r_is_sw    <= '0;
      r_is_hw    <= '0;
      r_is_ipi   <= 1'b0;
      r_ecode    <= '0;
      r_esubcode <= '0;
    end else begin
      if (w_we_ecfg) begin
        r_ecfg <= csr_merge(r_ecfg, w_wv, w_wm, c_ECFG_WMASK);
      end
      if (w_we_estat) begin
        r_is_sw <= (w_wv[c_ESTAT_IS_SW_HI:c_ESTAT_IS_SW_LO] & w_wm[c_ESTAT_IS_SW_HI:c_ESTAT_IS_SW_LO]) |
                   (r_is_sw & ~w_wm[c_ESTAT_IS_SW_HI:c_ESTAT_IS_SW_LO]);
      end
      r_is_hw  <= bus.hw_int_in;
      r_is_ipi <= bus.ipi_int_in;
      if (bus.wb_ex) begin
        r_ecode    <= bus.wb_ecode;
        r_esubcode <= bus.wb_esubcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_era    <= '0;
      r_eentry <= '0;
      r_tid    <= TID_RESET;
      for (int i = 0; i < c_NUM_SAVE; i++) begin
        r_save[i] <= '0;
      end
    end else begin
      if (w_we_era) begin
        r_era <= csr_merge(r_era, w_wv, w_wm, c_FULL_WMASK);
      end
      if (bus.wb_ex) begin
        r_era <= bus.wb_pc;
      end
      if (w_we_eentry) begin
        r_eentry <= csr_merge(r_eentry, w_wv, w_wm, c_EENTRY_WMASK);
      end
      if (w_we_tid) begin
        r_tid <= csr_merge(r_tid, w_wv, w_wm, c_FULL_WMASK);
      end
      for (int i = 0; i < c_NUM_SAVE; i++) begin
        if (bus.csr_we && (bus.csr_num == (c_CSR_SAVE0 + c_CSR_NUM_W'(i)))) begin
          r_save[i] <= csr_merge(r_save[i], w_wv, w_wm, c_FULL_WMASK);
        end
      end
    end
  end

  csr_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_tcfg_we (w_we_tcfg),
    .i_wmask   (w_wm),
    .i_wvalue  (w_wv),
    .i_ticlr   (w_ticlr),
    .o_tcfg    (w_tcfg),
    .o_tval    (w_tval),
    .o_ti      (w_ti)
  );

  always_comb begin
    w_estat = '0;
    w_estat[c_ESTAT_IS_SW_HI:c_ESTAT_IS_SW_LO] = r_is_sw;
    w_estat[c_ESTAT_IS_HW_HI:c_ESTAT_IS_HW_LO] = r_is_hw;
    w_estat[c_ESTAT_IS_TI]                     = w_ti;
    w_estat[c_ESTAT_IS_IPI]                    = r_is_ipi;
    w_estat[c_ESTAT_ECODE_HI:c_ESTAT_ECODE_LO] = r_ecode;
    w_estat[c_ESTAT_ESUB_HI:c_ESTAT_ESUB_LO]   = r_esubcode;
  end

  always_comb begin
    w_rvalue = '0;
    if (bus.csr_re) begin
      case (bus.csr_num)
        c_CSR_CRMD:   w_rvalue = r_crmd;
        c_CSR_PRMD:   w_rvalue = r_prmd;
        c_CSR_ECFG:   w_rvalue = r_ecfg;
        c_CSR_ESTAT:  w_rvalue = w_estat;
        c_CSR_ERA:    w_rvalue = r_era;
        c_CSR_EENTRY: w_rvalue = r_eentry;
        c_CSR_SAVE0:  w_rvalue = r_save[0];
        c_CSR_SAVE1:  w_rvalue = r_save[1];
        c_CSR_SAVE2:  w_rvalue = r_save[2];
        c_CSR_SAVE3:  w_rvalue = r_save[3];
        c_CSR_TID:    w_rvalue = r_tid;
        c_CSR_TCFG:   w_rvalue = w_tcfg;
        c_CSR_TVAL:   w_rvalue = w_tval;
        default:      w_rvalue = '0;
      endcase
    end
  end

  assign bus.csr_rvalue = w_rvalue;
  assign bus.ex_entry   = r_eentry;
  assign bus.ertn_pc    = r_era;
  assign bus.has_int    = (|(w_estat[c_ESTAT_IS_HI:0] & r_ecfg[c_ESTAT_IS_HI:0])) & r_crmd[c_CRMD_IE];

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_regfile
//  Description : Scoreboard bench for csr_regfile. Stimulus tasks push the
//                hand-computed expected value of each observation into a
//                queue; an independent monitor pops and compares whenever a
//                read or an observation is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  localparam logic [31:0] c_TID_RST = 32'h1234_5678;

  // Observation kinds
  localparam int c_K_RVALUE = 0;
  localparam int c_K_HASINT = 1;
  localparam int c_K_ENTRY  = 2;
  localparam int c_K_ERTN   = 3;
  localparam int c_K_RE_LOW = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic obs_valid = 1'b0;
  logic final_chk = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb [$];

  csr_regfile_if bus ();

  csr_regfile #(.TID_RESET(c_TID_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: compares away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (final_chk) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
      end
    end else if (!reset && (bus.csr_re || obs_valid)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: output presented with no expectation");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          c_K_HASINT: act = {31'd0, bus.has_int};
          c_K_ENTRY:  act = bus.ex_entry;
          c_K_ERTN:   act = bus.ertn_pc;
          default:    act = bus.csr_rvalue;
        endcase
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got %08h required %08h (mask %08h)", e.name, act & e.mask, e.exp & e.mask, e.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] exp, input logic [31:0] mask, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.mask = mask; e.name = name;
    sb.push_back(e);
  endtask

  task automatic rdm(input logic [13:0] num, input logic [31:0] exp, input logic [31:0] mask, input string name);
    push(c_K_RVALUE, exp, mask, name);
    bus.csr_re = 1'b1; bus.csr_num = num;
    tick();
    bus.csr_re = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string name);
    rdm(num, exp, 32'hFFFF_FFFF, name);
  endtask

  task automatic obs(input int kind, input logic [31:0] exp, input string name);
    push(kind, exp, 32'hFFFF_FFFF, name);
    obs_valid = 1'b1;
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
    bus.csr_we = 1'b1; bus.csr_num = num; bus.csr_wvalue = val; bus.csr_wmask = mask;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.csr_re = 0; bus.csr_num = '0; bus.csr_we = 0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
    bus.wb_ex = 0; bus.wb_ecode = '0; bus.wb_esubcode = '0; bus.eret_flush = 0; bus.wb_pc = '0;
    bus.hw_int_in = '0; bus.ipi_int_in = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(c_CSR_CRMD,  32'h0000_0008, "rst_crmd");
    rd(c_CSR_TVAL,  32'hFFFF_FFFF, "rst_tval");
    rd(c_CSR_TID,   c_TID_RST,     "rst_tid");
    rd(c_CSR_PRMD,  32'h0,         "rst_prmd");
    rd(c_CSR_ESTAT, 32'h0,         "rst_estat");
    bus.csr_num = c_CSR_CRMD;
    obs(c_K_RE_LOW, 32'h0, "re_low_zero");

    // Unimplemented CSR
    wr(14'h007, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h007, 32'h0, "unimpl_read");

    // Masked writes
    wr(c_CSR_SAVE0, 32'hFFFF_FFFF, 32'h0000_FF00);
    rd(c_CSR_SAVE0, 32'h0000_FF00, "save0_mask1");
    wr(c_CSR_SAVE0, 32'h1234_5678, 32'hFFFF_0000);
    rd(c_CSR_SAVE0, 32'h1234_FF00, "save0_mask2");
    wr(c_CSR_SAVE3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    rd(c_CSR_SAVE3, 32'hA5A5_A5A5, "save3");
    rd(c_CSR_SAVE0, 32'h1234_FF00, "save0_kept");
    wr(c_CSR_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_CSR_ECFG, 32'h0000_1BFF, "ecfg_fields");
    wr(c_CSR_ECFG, 32'h0, 32'hFFFF_FFFF);
    wr(c_CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_CSR_EENTRY, 32'hFFFF_FFC0, "eentry_fields");
    obs(c_K_ENTRY, 32'hFFFF_FFC0, "ex_entry");
    wr(c_CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_CSR_ESTAT, 32'h0000_0003, "estat_sw_only");
    wr(c_CSR_ESTAT, 32'h0, 32'hFFFF_FFFF);
    rd(c_CSR_ESTAT, 32'h0, "estat_sw_clear");
    wr(c_CSR_TVAL, 32'h0000_0055, 32'hFFFF_FFFF);
    rd(c_CSR_TVAL, 32'hFFFF_FFFF, "tval_ro");

    // Exception entry and return
    wr(c_CSR_CRMD, 32'h0000_0007, 32'hFFFF_FFFF);
    rd(c_CSR_CRMD, 32'h0000_0007, "crmd_w7");
    bus.wb_ex = 1; bus.wb_ecode = 6'h0B; bus.wb_esubcode = 9'h0; bus.wb_pc = 32'h1C00_0100;
    tick();
    bus.wb_ex = 0;
    rd(c_CSR_CRMD,  32'h0000_0000, "ex_crmd");
    rd(c_CSR_PRMD,  32'h0000_0007, "ex_prmd");
    rd(c_CSR_ERA,   32'h1C00_0100, "ex_era");
    obs(c_K_ERTN,   32'h1C00_0100, "ertn_pc");
    rd(c_CSR_ESTAT, 32'h000B_0000, "ex_estat");
    bus.eret_flush = 1;
    tick();
    bus.eret_flush = 0;
    rd(c_CSR_CRMD, 32'h0000_0007, "eret_crmd");

    // Same-cycle write and exception: DA/PG from the write, PLV/IE cleared
    bus.csr_we = 1; bus.csr_num = c_CSR_CRMD; bus.csr_wvalue = 32'h1F; bus.csr_wmask = 32'hFFFF_FFFF;
    bus.wb_ex = 1; bus.wb_ecode = 6'h08; bus.wb_esubcode = 9'h001; bus.wb_pc = 32'h1C00_0200;
    tick();
    bus.csr_we = 0; bus.wb_ex = 0;
    rd(c_CSR_CRMD,  32'h0000_0018, "we_ex_crmd");
    rd(c_CSR_PRMD,  32'h0000_0007, "we_ex_prmd");
    rd(c_CSR_ERA,   32'h1C00_0200, "we_ex_era");
    rd(c_CSR_ESTAT, 32'h0048_0000, "we_ex_estat");
    // Same-cycle write and eret: PLV/IE from PRMD, DA/PG from the write
    bus.csr_we = 1; bus.csr_num = c_CSR_CRMD; bus.csr_wvalue = 32'h0; bus.csr_wmask = 32'hFFFF_FFFF;
    bus.eret_flush = 1;
    tick();
    bus.csr_we = 0; bus.eret_flush = 0;
    rd(c_CSR_CRMD, 32'h0000_0007, "we_eret_crmd");

    // Periodic timer, InitVal=2
    wr(c_CSR_TCFG, 32'h0000_000B, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) rd(c_CSR_TVAL, 32'(8 - i), "tval_periodic");
    rdm(c_CSR_ESTAT, 32'h800, 32'h800, "ti_set");
    wr(c_CSR_TICLR, 32'h1, 32'h1);
    rdm(c_CSR_ESTAT, 32'h0, 32'h800, "ti_cleared");
    rd(c_CSR_TICLR, 32'h0, "ticlr_read");
    rd(c_CSR_TCFG, 32'h0000_000B, "tcfg_read");
    idle(3);
    wr(c_CSR_TICLR, 32'h1, 32'h1);
    rdm(c_CSR_ESTAT, 32'h800, 32'h800, "ti_set_wins");

    // Stop timer, then one-shot interrupt
    wr(c_CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    wr(c_CSR_TICLR, 32'h1, 32'h1);
    rdm(c_CSR_ESTAT, 32'h0, 32'h800, "ti_clear2");
    wr(c_CSR_ECFG, 32'h0000_0800, 32'hFFFF_FFFF);
    obs(c_K_HASINT, 32'h0, "hasint_idle");
    wr(c_CSR_TCFG, 32'h0000_0005, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) rd(c_CSR_TVAL, 32'(4 - i), "tval_oneshot");
    obs(c_K_HASINT, 32'h1, "hasint_timer");
    rd(c_CSR_TVAL, 32'hFFFF_FFFF, "tval_wrap");
    rd(c_CSR_TVAL, 32'hFFFF_FFFF, "tval_stopped");
    wr(c_CSR_TICLR, 32'h1, 32'h1);
    obs(c_K_HASINT, 32'h0, "hasint_cleared");

    // Hardware and IPI interrupt lines are registered
    wr(c_CSR_ECFG, 32'h0000_0004, 32'hFFFF_FFFF);
    bus.hw_int_in = 8'h01;
    obs(c_K_HASINT, 32'h0, "hasint_hw_lat");
    obs(c_K_HASINT, 32'h1, "hasint_hw");
    bus.hw_int_in = 8'h00;
    wr(c_CSR_ECFG, 32'h0000_1000, 32'hFFFF_FFFF);
    bus.ipi_int_in = 1'b1;
    obs(c_K_HASINT, 32'h0, "hasint_ipi_lat");
    obs(c_K_HASINT, 32'h1, "hasint_ipi");
    bus.ipi_int_in = 1'b0;
    rdm(c_CSR_ESTAT, 32'h1000, 32'h1000, "estat_ipi");

    // Reset beats a simultaneous write and exception
    wr(c_CSR_TID, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    rd(c_CSR_TID, 32'hCAFE_F00D, "tid_write");
    reset = 1'b1;
    bus.csr_we = 1; bus.csr_num = c_CSR_TID; bus.csr_wvalue = 32'hDEAD_BEEF; bus.csr_wmask = 32'hFFFF_FFFF;
    bus.wb_ex = 1; bus.wb_pc = 32'h1C00_0300;
    tick();
    reset = 1'b0; bus.csr_we = 0; bus.wb_ex = 0;
    rd(c_CSR_TID,  c_TID_RST,     "rstprio_tid");
    rd(c_CSR_CRMD, 32'h0000_0008, "rstprio_crmd");
    rd(c_CSR_PRMD, 32'h0,         "rstprio_prmd");
    rd(c_CSR_TVAL, 32'hFFFF_FFFF, "rstprio_tval");

    idle(1);
    final_chk = 1'b1;
    tick();
    final_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
